spart_program_writer: RTL and testbench



---
 rtl/spart_pkg.sv | 23 ++
 rtl/loader_cksum.sv | 30 +++
 rtl/spart_program_writer.sv | 154 +++++++++++++++
 tb/tb_spart_program_writer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART program loader.
package spart_pkg;

  // Loader FSM states
  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CKSUM,
    DONE,
    ERR
  } loader_state_t;

  // Default frame start marker
  localparam logic [7:0] START_BYTE_DEFAULT = 8'hA5;

  // Width of the running frame checksum
  localparam int CKSUM_WIDTH = 8;

endpackage

// File: rtl/loader_cksum.sv
// Modulo-256 running checksum for the loader: clear at frame start,
// add every accepted length/data byte, compare against the trailing byte.
module loader_cksum
  import spart_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   add,
  input  logic [CKSUM_WIDTH-1:0] data_in,
  output logic                   match
);

  logic [CKSUM_WIDTH-1:0] sum_reg;

  // Accumulate accepted bytes; wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum_reg <= '0;
    end else if (add) begin
      sum_reg <= sum_reg + data_in;
    end
  end

  // Received checksum byte matches the running sum
  always_comb begin
    match = (sum_reg == data_in);
  end

endmodule

// File: rtl/spart_program_writer.sv
// Bootloader write side: parses A5-framed byte streams from the SPART
// receiver, assembles big-endian 16-bit words and writes them into program
// memory while holding the CPU in reset.
module spart_program_writer
  import spart_pkg::*;
#(
  parameter int         ADDR_WIDTH = 16,
  parameter logic [7:0] START_BYTE = START_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data,
  output logic                  mem_wr,
  output logic                  mem_en,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Memory holds 2**(ADDR_WIDTH-1) words; a frame may fill it exactly
  localparam int unsigned CAPACITY = 32'd1 << (ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH-2:0] COUNT_ONE = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};

  loader_state_t         state_reg, state_next;
  logic [15:0]           len_reg, len_next;
  logic [15:0]           word_reg, word_next;
  logic [ADDR_WIDTH-2:0] count_reg, count_next;

  logic        accept;
  logic        cks_clear;
  logic        cks_add;
  logic        cks_match;
  logic [15:0] len_full;

  loader_cksum u_cksum (
    .clk     (clk),
    .rst     (rst),
    .clear   (cks_clear),
    .add     (cks_add),
    .data_in (rx_data),
    .match   (cks_match)
  );

  // State and datapath registers; reset abandons any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      word_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      word_reg  <= word_next;
      count_reg <= count_next;
    end
  end

  // Next-state, datapath updates and checksum control
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    word_next  = word_reg;
    count_next = count_reg;
    cks_clear  = 1'b0;
    cks_add    = 1'b0;
    accept     = rx_valid && (state_reg != WRITE);
    len_full   = {len_reg[15:8], rx_data};

    case (state_reg)
      // Only the start marker (re)opens a frame from a resting state
      IDLE, DONE, ERR: begin
        if (accept && (rx_data == START_BYTE)) begin
          state_next = LEN_HI;
          len_next   = '0;
          count_next = '0;
          cks_clear  = 1'b1;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_next[15:8] = rx_data;
          cks_add        = 1'b1;
          state_next     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_next[7:0] = rx_data;
          cks_add       = 1'b1;
          if (32'(len_full) > CAPACITY) begin
            state_next = ERR;
          end else if (len_full == 16'd0) begin
            state_next = CKSUM;
          end else begin
            state_next = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) begin
          word_next[15:8] = rx_data;
          cks_add         = 1'b1;
          state_next      = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept) begin
          word_next[7:0] = rx_data;
          cks_add        = 1'b1;
          state_next     = WRITE;
        end
      end
      // Single stall cycle per word while the write strobe is out
      WRITE: begin
        count_next = count_reg + COUNT_ONE;
        if ((32'(count_reg) + 32'd1) == 32'(len_reg)) begin
          state_next = CKSUM;
        end else begin
          state_next = DATA_HI;
        end
      end
      CKSUM: begin
        if (accept) begin
          state_next = cks_match ? DONE : ERR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    rx_ready = (state_reg != WRITE);
    mem_wr   = (state_reg == WRITE);
    mem_en   = (state_reg == WRITE);
    mem_addr = '0;
    mem_data = '0;
    if (state_reg == WRITE) begin
      mem_addr = {count_reg, 1'b0};
      mem_data = word_reg;
    end
    busy     = !((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
    cpu_hold = busy;
    done     = (state_reg == DONE);
    err      = (state_reg == ERR);
  end

endmodule

// File: tb/tb_spart_program_writer.sv
// Scoreboard bench for spart_program_writer with an 8-word memory.
module tb_spart_program_writer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          mem_wr;
  logic          mem_en;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  frame_q[$];

  spart_program_writer #(
    .ADDR_WIDTH (AW),
    .START_BYTE (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wr   (mem_wr),
    .mem_en   (mem_en),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_wr(input int addr, input logic [15:0] d);
    exp_q.push_back((32'(addr) << 16) | 32'(d));
  endtask

  // Monitor: every write strobe pops one expected (addr,data) pair
  always @(negedge clk) begin
    if (mem_wr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'({mem_addr, mem_data}), 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", 32'({mem_addr, mem_data}), e);
        $display("write addr=%0h data=%04h", mem_addr, mem_data);
      end
      check("write_mem_en", 32'(mem_en), 32'd1);
      check("write_stall_ready", 32'(rx_ready), 32'd0);
    end
  end

  // Present one byte, wait (bounded) for ready, complete the transfer
  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    tries = 0;
    while (!rx_ready && tries < 8) begin
      @(negedge clk);
      tries++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      if (i == 0 && frame_q[0] == 8'hA5) begin
        check("hold_after_start", 32'(cpu_hold), 32'd1);
        check("busy_after_start", 32'(busy), 32'd1);
      end
    end
    $display("frame of %0d bytes sent: done=%0b err=%0b hold=%0b", frame_q.size(), done, err, cpu_hold);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Nominal two-word frame, checksum 0xC0
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    push_wr(0, 16'h1234);
    push_wr(2, 16'hABCD);
    send_frame(0);
    check_status("nominal", 1'b1, 1'b0);

    // Same frame with a bad checksum: words still written
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
    push_wr(0, 16'h1234);
    push_wr(2, 16'hABCD);
    send_frame(0);
    check_status("badsum", 1'b0, 1'b1);

    // Zero-length frame
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    check_status("zerolen", 1'b1, 1'b0);

    // Exactly full memory: 8 words 0x0001..0x0008, checksum 8+36 = 0x2C
    frame_q = '{8'hA5, 8'h00, 8'h08};
    for (int k = 1; k <= 8; k++) begin
      frame_q.push_back(8'h00);
      frame_q.push_back(8'(k));
      push_wr(2 * (k - 1), 16'(k));
    end
    frame_q.push_back(8'h2C);
    send_frame(0);
    check_status("fullmem", 1'b1, 1'b0);

    // Oversize length: error right after the low length byte
    frame_q = '{8'hA5, 8'h00, 8'h09};
    send_frame(0);
    check_status("oversize", 1'b0, 1'b1);
    frame_q = '{8'h12, 8'h34, 8'h56, 8'h00};
    send_frame(0);
    check_status("oversize_ignore", 1'b0, 1'b1);

    // Reset in the middle of a frame, right after the first write
    frame_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    push_wr(0, 16'h1122);
    send_frame(0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_rx_ready", 32'(rx_ready), 32'd1);
    check("midrst_mem_wr", 32'(mem_wr), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    check_status("midrst", 1'b0, 1'b0);

    // Frame with an in-band A5A5 word, gap-free then with random gaps;
    // checksum 2+A5+A5+12+34 = 0x192 -> 0x92
    for (int pass = 0; pass < 2; pass++) begin
      frame_q = '{8'hA5, 8'h00, 8'h02, 8'hA5, 8'hA5, 8'h12, 8'h34, 8'h92};
      push_wr(0, 16'hA5A5);
      push_wr(2, 16'h1234);
      send_frame(pass * 4);
      check_status(pass == 0 ? "inband" : "gapped", 1'b1, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
